ts_os_receiver: RTL and testbench

- Per-lane receive-side parser for Gen1/Gen2 TS1/TS2 training ordered sets.
- Consumes the decoded 8b/10b symbol stream and extracts the link number, lane number, N_FTS, rate ID and training-control fields.
- Tracks consecutive identical ordered sets and flags the "REQ_CONSEC consecutive TS1/TS2 received" condition.
- The LTSSM controller uses these flags for Polling/Configuration/Recovery exits; this block is the receive counterpart of the LTSSM's TS1/TS2 transmission.

---
 rtl/ts_os_receiver.sv | 193 +++++++++++++++++++
 tb/tb_ts_os_receiver.sv | 316 +++++++++++++++++++++++++++++++
 2 files changed

// File: rtl/ts_os_receiver.sv
`default_nettype none
// ============================================================================
//  Module      : ts_os_receiver
//  Description : Per-lane receive parser for Gen1/Gen2 TS1/TS2 ordered sets.
//                Extracts link/lane/N_FTS/rate/control fields, reports well
//                formed and malformed sets, and tracks runs of identical sets.
//  Revision    : 1.0 - initial release
// ============================================================================
module ts_os_receiver #(
  parameter int REQ_CONSEC = 8,
  parameter int CNT_W      = 4
) (
  input  logic             clk_i,
  input  logic             rst_ni,
  input  logic             sym_valid_i,
  input  logic [7:0]       sym_data_i,
  input  logic             sym_is_k_i,
  input  logic             clear_i,
  output logic             os_valid_o,
  output logic [1:0]       os_type_o,
  output logic [7:0]       link_num_o,
  output logic             link_pad_o,
  output logic [7:0]       lane_num_o,
  output logic             lane_pad_o,
  output logic [7:0]       n_fts_o,
  output logic [7:0]       rate_id_o,
  output logic [7:0]       train_ctrl_o,
  output logic [CNT_W-1:0] consec_cnt_o,
  output logic             ts1_consec_o,
  output logic             ts2_consec_o,
  output logic             os_err_o
);

  localparam logic [7:0]       C_COM     = 8'hBC;
  localparam logic [7:0]       C_PAD     = 8'hF7;
  localparam logic [7:0]       C_TS1     = 8'h4A;
  localparam logic [7:0]       C_TS2     = 8'h45;
  localparam logic [CNT_W-1:0] C_CNT_MAX = '1;
  localparam logic [CNT_W-1:0] C_REQ     = CNT_W'(REQ_CONSEC);

  typedef enum logic [0:0] {
    S_HUNT    = 1'b0,
    S_COLLECT = 1'b1
  } state_t;

  state_t           r_state;
  logic [3:0]       r_idx;
  // Fields of the set currently being collected
  logic [7:0]       r_cap_link, r_cap_lane, r_cap_nfts, r_cap_rate, r_cap_ctrl, r_cap_id;
  logic             r_cap_link_pad, r_cap_lane_pad;
  // Published fields; together with r_store_vld they form the previous-set store
  logic             r_os_valid, r_os_err, r_store_vld;
  logic [1:0]       r_os_type;
  logic [7:0]       r_link, r_lane, r_nfts, r_rate, r_ctrl;
  logic             r_link_pad, r_lane_pad;
  logic [CNT_W-1:0] r_cnt;

  logic             w_is_com, w_is_pad, w_abort, w_same;
  logic [1:0]       w_new_type;
  logic [CNT_W-1:0] w_cnt_inc;

  assign w_is_com   = sym_is_k_i && (sym_data_i == C_COM);
  assign w_is_pad   = sym_is_k_i && (sym_data_i == C_PAD);
  assign w_new_type = (r_cap_id == C_TS1) ? 2'b01 : 2'b10;
  assign w_cnt_inc  = (r_cnt == C_CNT_MAX) ? r_cnt : r_cnt + 1'b1;
  // Symbol 5 is already captured by the time symbol 15 is judged
  assign w_same     = r_store_vld && (r_os_type == w_new_type) &&
                      (r_link == r_cap_link) && (r_link_pad == r_cap_link_pad) &&
                      (r_lane == r_cap_lane) && (r_lane_pad == r_cap_lane_pad) &&
                      (r_nfts == r_cap_nfts) && (r_rate == r_cap_rate) &&
                      (r_ctrl == r_cap_ctrl);

  // Legality of the current symbol at its position within the set (COM handled separately)
  always_comb begin
    w_abort = 1'b0;
    if (r_idx == 4'd1 || r_idx == 4'd2)
      w_abort = sym_is_k_i && !w_is_pad;
    else if (r_idx <= 4'd5)
      w_abort = sym_is_k_i;
    else if (r_idx == 4'd6)
      w_abort = sym_is_k_i || ((sym_data_i != C_TS1) && (sym_data_i != C_TS2));
    else
      w_abort = sym_is_k_i || (sym_data_i != r_cap_id);
  end

  // Symbol-collection FSM, field capture, publication and consecutive tracking
  always_ff @(posedge clk_i or negedge rst_ni) begin
    if (!rst_ni) begin
      r_state        <= S_HUNT;
      r_idx          <= 4'd0;
      r_cap_link     <= 8'd0;
      r_cap_lane     <= 8'd0;
      r_cap_nfts     <= 8'd0;
      r_cap_rate     <= 8'd0;
      r_cap_ctrl     <= 8'd0;
      r_cap_id       <= 8'd0;
      r_cap_link_pad <= 1'b0;
      r_cap_lane_pad <= 1'b0;
      r_os_valid     <= 1'b0;
      r_os_err       <= 1'b0;
      r_store_vld    <= 1'b0;
      r_os_type      <= 2'b00;
      r_link         <= 8'd0;
      r_lane         <= 8'd0;
      r_nfts         <= 8'd0;
      r_rate         <= 8'd0;
      r_ctrl         <= 8'd0;
      r_link_pad     <= 1'b0;
      r_lane_pad     <= 1'b0;
      r_cnt          <= '0;
    end else begin
      r_os_valid <= 1'b0;
      r_os_err   <= 1'b0;
      if (sym_valid_i) begin
        case (r_state)
          S_HUNT: begin
            if (w_is_com) begin
              r_state <= S_COLLECT;
              r_idx   <= 4'd1;
            end
          end
          S_COLLECT: begin
            if (w_is_com) begin
              // Unexpected COM: report the broken set and resynchronise on this COM
              r_os_err    <= 1'b1;
              r_cnt       <= '0;
              r_store_vld <= 1'b0;
              r_idx       <= 4'd1;
            end else if (w_abort) begin
              r_os_err    <= 1'b1;
              r_cnt       <= '0;
              r_store_vld <= 1'b0;
              r_state     <= S_HUNT;
              r_idx       <= 4'd0;
            end else begin
              case (r_idx)
                4'd1: begin r_cap_link <= sym_data_i; r_cap_link_pad <= sym_is_k_i; end
                4'd2: begin r_cap_lane <= sym_data_i; r_cap_lane_pad <= sym_is_k_i; end
                4'd3: r_cap_nfts <= sym_data_i;
                4'd4: r_cap_rate <= sym_data_i;
                4'd5: r_cap_ctrl <= sym_data_i;
                4'd6: r_cap_id   <= sym_data_i;
                default: ;
              endcase
              if (r_idx == 4'd15) begin
                r_os_valid  <= 1'b1;
                r_os_type   <= w_new_type;
                r_link      <= r_cap_link;
                r_link_pad  <= r_cap_link_pad;
                r_lane      <= r_cap_lane;
                r_lane_pad  <= r_cap_lane_pad;
                r_nfts      <= r_cap_nfts;
                r_rate      <= r_cap_rate;
                r_ctrl      <= r_cap_ctrl;
                r_cnt       <= w_same ? w_cnt_inc : {{(CNT_W-1){1'b0}}, 1'b1};
                r_store_vld <= 1'b1;
                r_state     <= S_HUNT;
                r_idx       <= 4'd0;
              end else begin
                r_idx <= r_idx + 4'd1;
              end
            end
          end
          default: begin
            r_state <= S_HUNT;
            r_idx   <= 4'd0;
          end
        endcase
      end
      // LTSSM state change restarts run tracking; overrides any update above
      if (clear_i) begin
        r_cnt       <= '0;
        r_store_vld <= 1'b0;
      end
    end
  end

  assign os_valid_o   = r_os_valid;
  assign os_err_o     = r_os_err;
  assign os_type_o    = r_os_type;
  assign link_num_o   = r_link;
  assign link_pad_o   = r_link_pad;
  assign lane_num_o   = r_lane;
  assign lane_pad_o   = r_lane_pad;
  assign n_fts_o      = r_nfts;
  assign rate_id_o    = r_rate;
  assign train_ctrl_o = r_ctrl;
  assign consec_cnt_o = r_cnt;
  assign ts1_consec_o = (r_os_type == 2'b01) && (r_cnt >= C_REQ);
  assign ts2_consec_o = (r_os_type == 2'b10) && (r_cnt >= C_REQ);

endmodule
`default_nettype wire

// File: tb/tb_ts_os_receiver.sv
`default_nettype none
// ============================================================================
//  Module      : tb_ts_os_receiver
//  Description : Directed and randomized bench for ts_os_receiver with a
//                set-level reference model.
//  Revision    : 1.0 - initial release
// ============================================================================
module tb_ts_os_receiver;

  localparam int REQ  = 8;
  localparam int CW   = 4;
  localparam int CMAX = 15;

  logic          clk_i = 1'b0;
  logic          rst_ni = 1'b0;
  logic          sym_valid_i = 1'b0;
  logic [7:0]    sym_data_i = 8'd0;
  logic          sym_is_k_i = 1'b0;
  logic          clear_i = 1'b0;
  logic          os_valid_o, link_pad_o, lane_pad_o, ts1_consec_o, ts2_consec_o, os_err_o;
  logic [1:0]    os_type_o;
  logic [7:0]    link_num_o, lane_num_o, n_fts_o, rate_id_o, train_ctrl_o;
  logic [CW-1:0] consec_cnt_o;

  ts_os_receiver #(.REQ_CONSEC(REQ), .CNT_W(CW)) dut (
    .clk_i(clk_i), .rst_ni(rst_ni), .sym_valid_i(sym_valid_i),
    .sym_data_i(sym_data_i), .sym_is_k_i(sym_is_k_i), .clear_i(clear_i),
    .os_valid_o(os_valid_o), .os_type_o(os_type_o), .link_num_o(link_num_o),
    .link_pad_o(link_pad_o), .lane_num_o(lane_num_o), .lane_pad_o(lane_pad_o),
    .n_fts_o(n_fts_o), .rate_id_o(rate_id_o), .train_ctrl_o(train_ctrl_o),
    .consec_cnt_o(consec_cnt_o), .ts1_consec_o(ts1_consec_o),
    .ts2_consec_o(ts2_consec_o), .os_err_o(os_err_o)
  );

  always #5 clk_i = ~clk_i;

  int checks = 0;
  int failures = 0;

  // Current ordered set image (16 symbols)
  logic [7:0] os_d[16];
  logic       os_k[16];

  // Pulse observation
  int n_valid, n_err, valid_pos, err_pos, cur_pos;

  // Reference model state: last good set, run length, store validity
  int         m_cnt;
  bit         m_prev_vld;
  logic [1:0] m_type;
  logic [7:0] m_link, m_lane, m_nfts, m_rate, m_ctrl;
  logic       m_lpad, m_lnpad;

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    checks++;
    assert (obs === exp) else begin
      failures++;
      $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
    end
  endtask

  task automatic model_reset();
    m_cnt = 0; m_prev_vld = 0; m_type = 2'b00;
    m_link = 0; m_lane = 0; m_nfts = 0; m_rate = 0; m_ctrl = 0;
    m_lpad = 0; m_lnpad = 0;
  endtask

  task automatic build_ts(input bit ts1, input bit lpad, input logic [7:0] link,
                          input bit lnpad, input logic [7:0] lane, input logic [7:0] nfts,
                          input logic [7:0] rate, input logic [7:0] ctrl);
    os_d[0] = 8'hBC; os_k[0] = 1'b1;
    os_d[1] = lpad  ? 8'hF7 : link; os_k[1] = lpad;
    os_d[2] = lnpad ? 8'hF7 : lane; os_k[2] = lnpad;
    os_d[3] = nfts; os_k[3] = 1'b0;
    os_d[4] = rate; os_k[4] = 1'b0;
    os_d[5] = ctrl; os_k[5] = 1'b0;
    for (int i = 6; i < 16; i++) begin
      os_d[i] = ts1 ? 8'h4A : 8'h45;
      os_k[i] = 1'b0;
    end
  endtask

  // First illegal position of the current set image, or 0 when it is well formed
  function automatic int classify();
    for (int p = 1; p < 16; p++) begin
      if (p <= 2) begin
        if (os_k[p] && os_d[p] != 8'hF7) return p;
      end else if (p <= 5) begin
        if (os_k[p]) return p;
      end else if (p == 6) begin
        if (os_k[p] || !(os_d[p] == 8'h4A || os_d[p] == 8'h45)) return p;
      end else begin
        if (os_k[p] || os_d[p] != os_d[6]) return p;
      end
    end
    return 0;
  endfunction

  task automatic model_apply(input int bad, input bit clr);
    logic [1:0] nt;
    bit same;
    if (bad != 0) begin
      m_cnt = 0; m_prev_vld = 0;
    end else begin
      nt = (os_d[6] == 8'h4A) ? 2'b01 : 2'b10;
      same = m_prev_vld && nt == m_type && os_d[1] == m_link && os_k[1] == m_lpad &&
             os_d[2] == m_lane && os_k[2] == m_lnpad && os_d[3] == m_nfts &&
             os_d[4] == m_rate && os_d[5] == m_ctrl;
      m_type = nt; m_link = os_d[1]; m_lpad = os_k[1]; m_lane = os_d[2];
      m_lnpad = os_k[2]; m_nfts = os_d[3]; m_rate = os_d[4]; m_ctrl = os_d[5];
      m_cnt = same ? ((m_cnt < CMAX) ? m_cnt + 1 : CMAX) : 1;
      m_prev_vld = 1;
    end
    if (clr) begin
      m_cnt = 0; m_prev_vld = 0;
    end
  endtask

  task automatic sample();
    if (os_valid_o === 1'b1) begin n_valid++; valid_pos = cur_pos; end
    if (os_err_o === 1'b1) begin n_err++; err_pos = cur_pos; end
  endtask

  task automatic clear_obs();
    n_valid = 0; n_err = 0; valid_pos = -1; err_pos = -1;
  endtask

  // One valid symbol, optionally preceded by an idle (sym_valid_i=0) cycle carrying junk
  task automatic drive_sym(input logic [7:0] d, input logic k, input int pos,
                           input bit clr, input bit gap);
    if (gap) begin
      sym_valid_i = 1'b0; sym_data_i = 8'($urandom); sym_is_k_i = 1'($urandom); clear_i = 1'b0;
      @(posedge clk_i); #1; sample();
    end
    sym_valid_i = 1'b1; sym_data_i = d; sym_is_k_i = k; clear_i = clr; cur_pos = pos;
    @(posedge clk_i); #1; sample();
    clear_i = 1'b0;
  endtask

  task automatic check_pulses(input string tag, input int bad);
    if (bad == 0) begin
      chk({tag, "_valid_n"}, n_valid, 1);
      chk({tag, "_valid_pos"}, valid_pos, 15);
      chk({tag, "_err_n"}, n_err, 0);
    end else begin
      chk({tag, "_err_n"}, n_err, 1);
      chk({tag, "_err_pos"}, err_pos, bad);
      chk({tag, "_valid_n"}, n_valid, 0);
    end
  endtask

  task automatic check_state(input string tag);
    chk({tag, "_type"}, os_type_o, m_type);
    chk({tag, "_link"}, {link_pad_o, link_num_o}, {m_lpad, m_link});
    chk({tag, "_lane"}, {lane_pad_o, lane_num_o}, {m_lnpad, m_lane});
    chk({tag, "_fields"}, {n_fts_o, rate_id_o, train_ctrl_o}, {m_nfts, m_rate, m_ctrl});
    chk({tag, "_cnt"}, consec_cnt_o, m_cnt);
    chk({tag, "_ts1c"}, ts1_consec_o, (m_type == 2'b01 && m_cnt >= REQ));
    chk({tag, "_ts2c"}, ts2_consec_o, (m_type == 2'b10 && m_cnt >= REQ));
  endtask

  task automatic run_os(input string tag, input bit gap, input bit clr);
    int bad;
    clear_obs();
    for (int i = 0; i < 16; i++) drive_sym(os_d[i], os_k[i], i, clr && i == 15, gap);
    sym_valid_i = 1'b0;
    bad = classify();
    model_apply(bad, clr);
    check_pulses(tag, bad);
    check_state(tag);
  endtask

  task automatic check_zero(input string tag);
    chk({tag, "_pulses"}, {os_valid_o, os_err_o}, 2'b00);
    chk({tag, "_type"}, os_type_o, 2'b00);
    chk({tag, "_fields"}, {link_pad_o, link_num_o, lane_pad_o, lane_num_o,
                           n_fts_o, rate_id_o, train_ctrl_o}, 32'd0);
    chk({tag, "_cnt"}, {ts1_consec_o, ts2_consec_o, consec_cnt_o}, 0);
  endtask

  initial begin
    #2_000_000;
    $display("FAIL watchdog observed=timeout expected=finish");
    $fatal(1, "watchdog");
  end

  initial begin
    bit         r_t1, r_lp, r_np;
    logic [7:0] r_link, r_lane, r_nfts, r_rate, r_ctrl;
    int         p;

    model_reset();
    cur_pos = 0;
    clear_obs();
    repeat (2) @(posedge clk_i);
    #1;
    check_zero("reset");
    rst_ni = 1'b1;
    @(posedge clk_i); #1;

    // 8 back-to-back identical TS1 with PAD link/lane
    for (int i = 0; i < 8; i++) begin
      build_ts(1, 1, 8'h00, 1, 8'h00, 8'h10, 8'h02, 8'h00);
      run_os("ts1_run", 0, 0);
      if (i == 6) chk("ts1_run_7th", {ts1_consec_o, consec_cnt_o}, {1'b0, 4'd7});
      if (i == 7) chk("ts1_run_8th", {ts1_consec_o, link_pad_o, lane_pad_o, consec_cnt_o},
                      {3'b111, 4'd8});
    end
    // Run continues into saturation, then a changed N_FTS breaks it
    for (int i = 0; i < 7; i++) begin
      build_ts(1, 1, 8'h00, 1, 8'h00, 8'h10, 8'h02, 8'h00);
      run_os("ts1_sat", 0, 0);
    end
    chk("ts1_sat_max", consec_cnt_o, 15);
    build_ts(1, 1, 8'h00, 1, 8'h00, 8'h20, 8'h02, 8'h00);
    run_os("nfts_chg", 0, 0);
    chk("nfts_chg_cnt", {ts1_consec_o, consec_cnt_o}, {1'b0, 4'd1});
    for (int i = 0; i < 8; i++) begin
      build_ts(1, 1, 8'h00, 1, 8'h00, 8'h20, 8'h02, 8'h00);
      run_os("nfts_run", 0, 0);
    end

    // TS2 with a TS1 identifier at symbol 11 aborts, next clean TS2 starts a new run
    build_ts(0, 0, 8'h05, 0, 8'h03, 8'h10, 8'h02, 8'h00);
    os_d[11] = 8'h4A;
    run_os("ts2_bad", 0, 0);
    chk("ts2_bad_cnt", consec_cnt_o, 0);
    build_ts(0, 0, 8'h05, 0, 8'h03, 8'h10, 8'h02, 8'h00);
    run_os("ts2_good", 0, 0);
    chk("ts2_good_fields", {consec_cnt_o, link_num_o, lane_num_o}, {4'd1, 8'h05, 8'h03});

    // COM at symbol 9 resynchronises onto a complete TS1 body
    build_ts(1, 0, 8'h01, 0, 8'h02, 8'h10, 8'h02, 8'h00);
    clear_obs();
    for (int i = 0; i < 9; i++) drive_sym(os_d[i], os_k[i], i, 0, 0);
    drive_sym(8'hBC, 1'b1, 9, 0, 0);
    for (int i = 1; i < 16; i++) drive_sym(os_d[i], os_k[i], i, 0, 0);
    sym_valid_i = 1'b0;
    chk("resync_err_n", n_err, 1);
    chk("resync_err_pos", err_pos, 9);
    chk("resync_valid_n", n_valid, 1);
    chk("resync_valid_pos", valid_pos, 15);
    model_apply(9, 0);
    model_apply(0, 0);
    check_state("resync");

    // Break the run, then 10 TS1 with idle cycles between every symbol
    build_ts(1, 1, 8'h00, 1, 8'h00, 8'h10, 8'h02, 8'h00);
    os_d[8] = 8'h00;
    run_os("pre_gap_err", 0, 0);
    for (int i = 0; i < 10; i++) begin
      build_ts(1, 1, 8'h00, 1, 8'h00, 8'h10, 8'h02, 8'h00);
      run_os("gap_run", 1, 0);
    end
    chk("gap_run_end", {ts1_consec_o, consec_cnt_o}, {1'b1, 4'd10});

    // clear_i coincident with the 8th completion
    build_ts(1, 1, 8'h00, 1, 8'h00, 8'h10, 8'h02, 8'h00);
    os_d[7] = 8'h45;
    run_os("pre_clr_err", 0, 0);
    for (int i = 0; i < 8; i++) begin
      build_ts(1, 0, 8'h07, 0, 8'h01, 8'h30, 8'h02, 8'h08);
      run_os("clr_run", 0, i == 7);
    end
    chk("clr_end", {n_valid[0], ts1_consec_o, consec_cnt_o}, {2'b10, 4'd0});

    // Reset in the middle of a set: everything clears and the tail is ignored
    build_ts(1, 0, 8'h07, 0, 8'h01, 8'h30, 8'h02, 8'h08);
    for (int i = 0; i < 7; i++) drive_sym(os_d[i], os_k[i], i, 0, 0);
    rst_ni = 1'b0;
    #3;
    check_zero("mid_rst");
    @(posedge clk_i); #1;
    rst_ni = 1'b1;
    model_reset();
    clear_obs();
    for (int i = 7; i < 16; i++) drive_sym(os_d[i], os_k[i], i, 0, 0);
    sym_valid_i = 1'b0;
    chk("mid_rst_tail", {n_valid, n_err}, 0);
    run_os("post_rst", 0, 0);

    // Randomized sets: mostly repeats of the previous fields, occasional corruption
    r_t1 = 1; r_lp = 0; r_np = 0; r_link = 8'h01; r_lane = 8'h00;
    r_nfts = 8'h10; r_rate = 8'h02; r_ctrl = 8'h00;
    for (int n = 0; n < 60; n++) begin
      if ($urandom_range(0, 99) < 20) begin
        r_t1   = 1'($urandom);
        r_lp   = ($urandom_range(0, 3) == 0);
        r_np   = ($urandom_range(0, 3) == 0);
        r_link = 8'($urandom_range(0, 2));
        r_lane = 8'($urandom_range(0, 2));
        r_nfts = 8'($urandom_range(0, 1) * 16 + 16);
        r_rate = 8'($urandom_range(1, 2));
        r_ctrl = 8'($urandom_range(0, 1));
      end
      build_ts(r_t1, r_lp, r_link, r_np, r_lane, r_nfts, r_rate, r_ctrl);
      if ($urandom_range(0, 9) == 0) begin
        p = $urandom_range(1, 15);
        if ($urandom_range(0, 1) == 1) begin
          os_k[p] = 1'b1;
          os_d[p] = 8'($urandom);
          if (os_d[p] == 8'hBC) os_d[p] = 8'h1C;
        end else begin
          os_d[p] = os_d[p] ^ 8'($urandom_range(1, 255));
        end
      end
      run_os("rand", 1'($urandom), 0);
    end

    repeat (2) @(posedge clk_i);
    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule
`default_nettype wire
